galois_lfsr_gen: RTL and testbench



---
 rtl/galois_lfsr_gen.sv | 167 ++++++++++++++++
 tb/tb_galois_lfsr_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/galois_lfsr_gen.sv
// galois_lfsr_gen
//   Galois LFSR pseudo-random bit generator with seed loading, burst
//   generation of a programmed number of steps, abort and all-zero
//   lock-up recovery.
//
// Parameters
//   WIDTH  LFSR register width (>= 3)
//   POLY   Galois tap mask XORed into the shifted state when the
//          shifted-out bit is 1
//   SEED   reset value of the state (0 is replaced by 1)
//   CNT_W  width of the burst length counter
//
// Ports
//   i_clk        clock, rising-edge active
//   i_rst        asynchronous active-high reset
//   i_load       load i_seed_in into the state (IDLE only)
//   i_seed_in    seed value used by i_load
//   i_start      begin a burst of i_len steps (IDLE only)
//   i_len        burst length, sampled with i_start
//   i_stop       abort the current burst
//   o_q          current LFSR state
//   o_bit_out    bit shifted out by the most recent step
//   o_bit_valid  o_bit_out is fresh this cycle
//   o_busy       burst in progress
//   o_done       one-cycle burst completion pulse
//   o_lockup     one-cycle pulse: a zero state/seed was replaced by 1
module galois_lfsr_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed_in,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_q,
    output logic             o_bit_out,
    output logic             o_bit_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_lockup
);

    localparam logic [WIDTH-1:0] ONE_Q   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] RESET_Q = (SEED == '0) ? ONE_Q : SEED;
    localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bit_out;
    logic             r_bit_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_lockup;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_q_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_bit_out_next;
    logic             w_bit_valid_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_lockup_next;

    logic [WIDTH-1:0] w_shift;
    logic             w_shift_zero;

    // One Galois step; a zero result can only come from a bad POLY and
    // is replaced by 1 so the generator never sticks.
    assign w_shift      = {1'b0, r_q[WIDTH-1:1]} ^ (r_q[0] ? POLY : '0);
    assign w_shift_zero = (w_shift == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_q         <= RESET_Q;
            r_cnt       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_lockup    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_q         <= w_q_next;
            r_cnt       <= w_cnt_next;
            r_bit_out   <= w_bit_out_next;
            r_bit_valid <= w_bit_valid_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_lockup    <= w_lockup_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_q_next         = r_q;
        w_cnt_next       = r_cnt;
        w_bit_out_next   = r_bit_out;
        w_bit_valid_next = 1'b0;
        w_busy_next      = 1'b0;
        w_done_next      = 1'b0;
        w_lockup_next    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    if (i_seed_in == '0) begin
                        w_q_next      = ONE_Q;
                        w_lockup_next = 1'b1;
                    end else begin
                        w_q_next = i_seed_in;
                    end
                end else if (i_start) begin
                    if (i_len == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_cnt_next   = i_len;
                        w_busy_next  = 1'b1;
                        w_state_next = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (i_stop) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_q_next         = w_shift_zero ? ONE_Q : w_shift;
                    w_lockup_next    = w_shift_zero;
                    w_bit_out_next   = r_q[0];
                    w_bit_valid_next = 1'b1;
                    w_cnt_next       = r_cnt - ONE_CNT;
                    // Final step: DONE lands together with the last valid bit.
                    if (r_cnt == ONE_CNT) begin
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_busy_next = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_q         = r_q;
    assign o_bit_out   = r_bit_out;
    assign o_bit_valid = r_bit_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_lockup    = r_lockup;

endmodule

// File: tb/tb_galois_lfsr_gen.sv
// Testbench for galois_lfsr_gen: a behavioural model is compared with the
// 16-bit DUT on every falling edge, and directed vectors with literal
// expectations pin both the DUT and the model. A second 8-bit instance
// is exercised for its full period.
module tb_galois_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] seed_in = '0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        stop = 1'b0;
    logic [15:0] q;
    logic        bit_out, bit_valid, busy, done, lockup;

    logic        start8 = 1'b0;
    logic [7:0]  len8 = '0;
    logic [7:0]  q8;
    logic        bo8, bv8, busy8, done8, lock8;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    galois_lfsr_gen #(
        .WIDTH(16), .POLY(16'hB400), .SEED(16'hACE1), .CNT_W(16)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_seed_in(seed_in),
        .i_start(start), .i_len(len), .i_stop(stop),
        .o_q(q), .o_bit_out(bit_out), .o_bit_valid(bit_valid),
        .o_busy(busy), .o_done(done), .o_lockup(lockup)
    );

    galois_lfsr_gen #(
        .WIDTH(8), .POLY(8'hB8), .SEED(8'h01), .CNT_W(8)
    ) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_load(1'b0), .i_seed_in(8'h00),
        .i_start(start8), .i_len(len8), .i_stop(1'b0),
        .o_q(q8), .o_bit_out(bo8), .o_bit_valid(bv8),
        .o_busy(busy8), .o_done(done8), .o_lockup(lock8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: integer state, a count of remaining steps, and
    // the LFSR step written as plain division/modulo arithmetic.
    function automatic int unsigned lfsr_next(input int unsigned s);
        int unsigned r;
        r = (s / 2) ^ ((s % 2 == 1) ? 32'hB400 : 32'h0);
        return (r == 0) ? 1 : r;
    endfunction

    int unsigned m_q;
    int unsigned m_left;
    bit m_run, m_bo, m_bv, m_done, m_lock;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q = 32'hACE1; m_left = 0; m_run = 0;
            m_bo = 0; m_bv = 0; m_done = 0; m_lock = 0;
        end else begin
            m_bv = 0; m_done = 0; m_lock = 0;
            if (!m_run) begin
                if (load) begin
                    m_lock = (seed_in == 0);
                    m_q    = m_lock ? 1 : int'(seed_in);
                end else if (start) begin
                    if (len == 0) m_done = 1;
                    else begin
                        m_left = len;
                        m_run  = 1;
                    end
                end
            end else if (stop) begin
                m_run = 0;
            end else begin
                m_bo   = (m_q % 2 == 1);
                m_q    = lfsr_next(m_q);
                m_bv   = 1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1;
                    m_run  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle{q,bo,bv,busy,done,lock}",
            {11'd0, q, bit_out, bit_valid, busy, done, lockup},
            {11'd0, m_q[15:0], m_bo, m_bv, m_run, m_done, m_lock});
    end

    int n_valid = 0;
    int n_done  = 0;
    always @(negedge clk) begin
        if (bit_valid) n_valid++;
        if (done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_q [4];
    logic        exp_b [4];
    int          bad;

    initial begin
        exp_q[0] = 16'hE270; exp_q[1] = 16'h7138; exp_q[2] = 16'h389C; exp_q[3] = 16'h1C4E;
        exp_b[0] = 1'b1; exp_b[1] = 1'b0; exp_b[2] = 1'b0; exp_b[3] = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_q", q, 16'hACE1);
        chk("rst_flags", {bit_out, bit_valid, busy, done, lockup}, 5'b0);
        chk("rst_q8", q8, 8'h01);
        rst = 1'b0;
        tick();

        // Burst of 4
        start = 1'b1; len = 16'd4;
        tick();
        start = 1'b0;
        chk("burst_busy_start", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("burst_q", q, exp_q[i]);
            chk("burst_bit", bit_out, exp_b[i]);
            chk("burst_valid", bit_valid, 1'b1);
            chk("burst_busy", busy, (i < 3) ? 1'b1 : 1'b0);
            chk("burst_done", done, (i == 3) ? 1'b1 : 1'b0);
            if (i == 0) chk("model_pin_q", m_q, 32'hE270);
        end
        tick();
        chk("burst_after", {bit_valid, busy, done}, 3'b0);

        // Asynchronous reset mid-burst
        start = 1'b1; len = 16'd10;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", q, 16'hACE1);
        chk("async_rst_flags", {bit_valid, busy, done, lockup}, 4'b0);
        tick(); tick(); tick();
        chk("rst_hold_q", q, 16'hACE1);
        rst = 1'b0;
        tick();
        chk("rst_no_done", done, 1'b0);

        // Load
        load = 1'b1; seed_in = 16'h1234;
        tick();
        load = 1'b0;
        chk("load_q", q, 16'h1234);
        chk("load_lock", lockup, 1'b0);
        load = 1'b1; seed_in = 16'h0000;
        tick();
        load = 1'b0;
        chk("load0_q", q, 16'h0001);
        chk("load0_lock", lockup, 1'b1);
        tick();
        chk("load0_lock_pulse", lockup, 1'b0);
        load = 1'b1; seed_in = 16'hACE1; start = 1'b1; len = 16'd5;
        tick();
        load = 1'b0; start = 1'b0;
        chk("loadstart_q", q, 16'hACE1);
        chk("loadstart_busy", busy, 1'b0);
        tick();
        chk("loadstart_busy2", {busy, bit_valid}, 2'b0);

        // Abort in the third RUN cycle; LOAD/START during RUN ignored
        n_valid = 0; n_done = 0;
        start = 1'b1; len = 16'd10;
        tick();
        start = 1'b0;
        load = 1'b1; seed_in = 16'h5555; start = 1'b1; len = 16'd2;
        tick();
        load = 1'b0; start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_q", q, 16'h7138);
        chk("abort_flags", {busy, done, bit_valid}, 3'b0);
        tick(); tick();
        chk("abort_valids", n_valid, 2);
        chk("abort_dones", n_done, 0);

        // Zero length
        load = 1'b1; seed_in = 16'hACE1;
        tick();
        load = 1'b0;
        start = 1'b1; len = 16'd0;
        tick();
        start = 1'b0;
        chk("len0_done", done, 1'b1);
        chk("len0_vb", {bit_valid, busy}, 2'b0);
        chk("len0_q", q, 16'hACE1);
        tick();
        chk("len0_done_pulse", done, 1'b0);

        // Full period, 16-bit
        bad = 0;
        start = 1'b1; len = 16'hFFFF;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (q == 16'h0) bad++;
            if (i < 65535 && (q == 16'hACE1 || done)) bad++;
        end
        chk("period16_bad_cycles", bad, 0);
        chk("period16_q", q, 16'hACE1);
        chk("period16_done", done, 1'b1);

        // Full period, 8-bit (LEN = 2^CNT_W-1)
        bad = 0;
        start8 = 1'b1; len8 = 8'hFF;
        tick();
        start8 = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i == 1) chk("period8_first", q8, 8'hB8);
            if (q8 == 8'h0 || !bv8) bad++;
            if (i < 255 && (q8 == 8'h01 || done8)) bad++;
        end
        chk("period8_bad_cycles", bad, 0);
        chk("period8_q", q8, 8'h01);
        chk("period8_done", done8, 1'b1);
        tick();
        chk("period8_idle", {busy8, bv8, done8}, 3'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
